// File: rtl/m5_keyboard_matrix_if.sv
// Keyboard matrix bus: hps_io key events and CPU row reads towards the matrix, column data back.
interface m5_keyboard_matrix_if;
  logic [10:0] ps2_key_i;
  logic [2:0]  row_sel_i;
  logic        rd_i;
  logic [7:0]  col_o;
  logic        key_reset_o;

  modport master (output ps2_key_i, row_sel_i, rd_i, input col_o, key_reset_o);
  modport slave  (input ps2_key_i, row_sel_i, rd_i, output col_o, key_reset_o);
endinterface

// File: rtl/m5_keyboard_matrix.sv
// Sord M5 7x8 keyboard matrix fed by hps_io ps2_key events, with latch-until-read release
// semantics, a forced release timeout and the F12/Scroll Lock RESET key.
module m5_keyboard_matrix #(
  parameter logic [20:0] REL_TIMEOUT = 21'd1_000_000
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  m5_keyboard_matrix_if.slave kb
);
  localparam int unsigned ROWS  = 7;
  localparam int unsigned COLS  = 8;
  localparam int unsigned CNT_W = 21;

  logic [ROWS-1:0][COLS-1:0] mat_q, mat_d, seen_q, seen_d, pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       col_q, col_d;
  logic             key_reset_q, key_reset_d;
  logic             toggle_q, hist_vld_q;

  logic [7:0] code_c;
  logic       pressed_c, ext_c, event_c;
  logic [6:0] key_loc_c;
  logic [2:0] hit_row_c, hit_col_c, row_c;

  assign code_c    = kb.ps2_key_i[7:0];
  assign ext_c     = kb.ps2_key_i[8];
  assign pressed_c = kb.ps2_key_i[9];
  assign event_c   = hist_vld_q && (kb.ps2_key_i[10] != toggle_q);
  assign hit_row_c = key_loc_c[5:3];
  assign hit_col_c = key_loc_c[2:0];
  assign row_c     = kb.row_sel_i;

  assign kb.col_o       = col_q;
  assign kb.key_reset_o = key_reset_q;

  function automatic logic [6:0] loc(input logic [2:0] r, input logic [2:0] c);
    return {1'b1, r, c};
  endfunction

  // Scan code to {valid, row, col}; extended codes only count for right Ctrl and keypad Enter
  always_comb begin
    key_loc_c = '0;
    case (code_c)
      8'h14: key_loc_c = loc(3'd0, 3'd0);  8'h11: key_loc_c = loc(3'd0, 3'd1);
      8'h12: key_loc_c = loc(3'd0, 3'd2);  8'h59: key_loc_c = loc(3'd0, 3'd3);
      8'h29: key_loc_c = loc(3'd0, 3'd6);  8'h5A: key_loc_c = loc(3'd0, 3'd7);
      8'h16: key_loc_c = loc(3'd1, 3'd0);  8'h1E: key_loc_c = loc(3'd1, 3'd1);
      8'h26: key_loc_c = loc(3'd1, 3'd2);  8'h25: key_loc_c = loc(3'd1, 3'd3);
      8'h2E: key_loc_c = loc(3'd1, 3'd4);  8'h36: key_loc_c = loc(3'd1, 3'd5);
      8'h3D: key_loc_c = loc(3'd1, 3'd6);  8'h3E: key_loc_c = loc(3'd1, 3'd7);
      8'h15: key_loc_c = loc(3'd2, 3'd0);  8'h1D: key_loc_c = loc(3'd2, 3'd1);
      8'h24: key_loc_c = loc(3'd2, 3'd2);  8'h2D: key_loc_c = loc(3'd2, 3'd3);
      8'h2C: key_loc_c = loc(3'd2, 3'd4);  8'h35: key_loc_c = loc(3'd2, 3'd5);
      8'h3C: key_loc_c = loc(3'd2, 3'd6);  8'h43: key_loc_c = loc(3'd2, 3'd7);
      8'h1C: key_loc_c = loc(3'd3, 3'd0);  8'h1B: key_loc_c = loc(3'd3, 3'd1);
      8'h23: key_loc_c = loc(3'd3, 3'd2);  8'h2B: key_loc_c = loc(3'd3, 3'd3);
      8'h34: key_loc_c = loc(3'd3, 3'd4);  8'h33: key_loc_c = loc(3'd3, 3'd5);
      8'h3B: key_loc_c = loc(3'd3, 3'd6);  8'h42: key_loc_c = loc(3'd3, 3'd7);
      8'h1A: key_loc_c = loc(3'd4, 3'd0);  8'h22: key_loc_c = loc(3'd4, 3'd1);
      8'h21: key_loc_c = loc(3'd4, 3'd2);  8'h2A: key_loc_c = loc(3'd4, 3'd3);
      8'h32: key_loc_c = loc(3'd4, 3'd4);  8'h31: key_loc_c = loc(3'd4, 3'd5);
      8'h3A: key_loc_c = loc(3'd4, 3'd6);  8'h41: key_loc_c = loc(3'd4, 3'd7);
      8'h46: key_loc_c = loc(3'd5, 3'd0);  8'h45: key_loc_c = loc(3'd5, 3'd1);
      8'h4E: key_loc_c = loc(3'd5, 3'd2);  8'h55: key_loc_c = loc(3'd5, 3'd3);
      8'h49: key_loc_c = loc(3'd5, 3'd4);  8'h4A: key_loc_c = loc(3'd5, 3'd5);
      8'h66: key_loc_c = loc(3'd5, 3'd6);  8'h5D: key_loc_c = loc(3'd5, 3'd7);
      8'h44: key_loc_c = loc(3'd6, 3'd0);  8'h4D: key_loc_c = loc(3'd6, 3'd1);
      8'h54: key_loc_c = loc(3'd6, 3'd2);  8'h5B: key_loc_c = loc(3'd6, 3'd3);
      8'h4B: key_loc_c = loc(3'd6, 3'd4);  8'h4C: key_loc_c = loc(3'd6, 3'd5);
      8'h52: key_loc_c = loc(3'd6, 3'd6);
      default: key_loc_c = '0;
    endcase
    if (ext_c && (code_c != 8'h14) && (code_c != 8'h5A)) key_loc_c = '0;
  end

  // Next state: timeout, then row read (captures pre-cycle matrix), then the key event
  always_comb begin
    mat_d       = mat_q;
    seen_d      = seen_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    key_reset_d = key_reset_q;

    if (pend_q == '0) begin
      cnt_d = '0;
    end else if (cnt_q >= REL_TIMEOUT - 21'd1) begin
      mat_d  = mat_q & ~pend_q;
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 21'd1;
    end

    if (kb.rd_i) begin
      if (row_c == 3'd7) begin
        col_d = '0;
      end else begin
        col_d         = mat_q[row_c];
        seen_d[row_c] = '1;
        mat_d[row_c]  = mat_d[row_c] & ~pend_q[row_c];
        pend_d[row_c] = '0;
      end
    end

    if (event_c) begin
      if ((code_c == 8'h07) || (code_c == 8'h7E)) key_reset_d = pressed_c;
      if (key_loc_c[6]) begin
        if (pressed_c) begin
          mat_d[hit_row_c][hit_col_c]  = 1'b1;
          seen_d[hit_row_c][hit_col_c] = 1'b0;
          pend_d[hit_row_c][hit_col_c] = 1'b0;
        end else if (seen_q[hit_row_c][hit_col_c]) begin
          mat_d[hit_row_c][hit_col_c]  = 1'b0;
          pend_d[hit_row_c][hit_col_c] = 1'b0;
        end else begin
          pend_d[hit_row_c][hit_col_c] = 1'b1;
        end
      end
    end
  end

  // First clock after reset only samples the toggle bit so no stale event is seen
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mat_q       <= '0;
      seen_q      <= '0;
      pend_q      <= '0;
      cnt_q       <= '0;
      col_q       <= '0;
      key_reset_q <= 1'b0;
      toggle_q    <= 1'b0;
      hist_vld_q  <= 1'b0;
    end else begin
      mat_q       <= mat_d;
      seen_q      <= seen_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      key_reset_q <= key_reset_d;
      toggle_q    <= kb.ps2_key_i[10];
      hist_vld_q  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_m5_keyboard_matrix.sv
// Self-checking bench for m5_keyboard_matrix: directed scenarios plus random events and reads
// checked every cycle against a per-key reference model.
module tb_m5_keyboard_matrix;
  localparam int REL = 100;

  logic clk;
  logic rst_n;
  m5_keyboard_matrix_if bus();

  m5_keyboard_matrix #(.REL_TIMEOUT(21'(REL))) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .kb       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Key layout, row-major, 00 marks an empty position
  logic [7:0] layout [56] = '{
    8'h14, 8'h11, 8'h12, 8'h59, 8'h00, 8'h00, 8'h29, 8'h5A,
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
    8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A, 8'h41,
    8'h46, 8'h45, 8'h4E, 8'h55, 8'h49, 8'h4A, 8'h66, 8'h5D,
    8'h44, 8'h4D, 8'h54, 8'h5B, 8'h4B, 8'h4C, 8'h52, 8'h00};
  int loc_of [256];

  // Reference model: one record per physical key
  bit         m_down [7][8];
  bit         m_seen [7][8];
  bit         m_pend [7][8];
  int         m_cnt;
  logic [7:0] m_col;
  logic       m_kr;

  task automatic model_reset();
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 8; c++) begin
        m_down[r][c] = 0; m_seen[r][c] = 0; m_pend[r][c] = 0;
      end
    m_cnt = 0; m_col = 8'h00; m_kr = 1'b0;
  endtask

  task automatic model_cycle(input bit ev, input bit pr, input bit ext, input logic [7:0] code,
                             input bit rd, input logic [2:0] row);
    bit o_down [7][8];
    bit o_seen [7][8];
    bit o_pend [7][8];
    bit any_pend = 0;
    int k, r, c;
    o_down = m_down; o_seen = m_seen; o_pend = m_pend;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 8; j++) any_pend |= o_pend[i][j];
    if (!any_pend) m_cnt = 0;
    else if (m_cnt == REL - 1) begin
      for (int i = 0; i < 7; i++)
        for (int j = 0; j < 8; j++)
          if (o_pend[i][j]) begin m_down[i][j] = 0; m_pend[i][j] = 0; end
      m_cnt = 0;
    end else m_cnt++;
    if (rd) begin
      if (row == 3'd7) m_col = 8'h00;
      else
        for (int j = 0; j < 8; j++) begin
          m_col[j] = o_down[row][j];
          m_seen[row][j] = 1;
          if (o_pend[row][j]) begin m_down[row][j] = 0; m_pend[row][j] = 0; end
        end
    end
    if (ev) begin
      if (code == 8'h07 || code == 8'h7E) m_kr = pr;
      k = loc_of[code];
      if (ext && code != 8'h14 && code != 8'h5A) k = -1;
      if (k >= 0) begin
        r = k / 8; c = k % 8;
        if (pr) begin m_down[r][c] = 1; m_seen[r][c] = 0; m_pend[r][c] = 0; end
        else if (o_seen[r][c]) begin m_down[r][c] = 0; m_pend[r][c] = 0; end
        else m_pend[r][c] = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1 time unit later
  task automatic step(input bit ev, input bit pr, input bit ext, input logic [7:0] code,
                      input bit rd, input logic [2:0] row);
    @(negedge clk);
    if (ev) bus.ps2_key_i = {~bus.ps2_key_i[10], pr, ext, code};
    bus.rd_i = rd;
    bus.row_sel_i = row;
    @(posedge clk);
    model_cycle(ev, pr, ext, code, rd, row);
    #1;
    check("col_o", bus.col_o, m_col);
    check("key_reset_o", {7'd0, bus.key_reset_o}, {7'd0, m_kr});
  endtask

  task automatic press(input logic [7:0] code, input bit ext);
    step(1, 1, ext, code, 0, 3'd0);
  endtask
  task automatic release_key(input logic [7:0] code, input bit ext);
    step(1, 0, ext, code, 0, 3'd0);
  endtask
  task automatic read_row(input logic [2:0] row);
    step(0, 0, 0, 8'h00, 1, row);
  endtask
  task automatic idle();
    step(0, 0, 0, 8'h00, 0, 3'd0);
  endtask

  logic [7:0] rnd_codes [14] = '{8'h1C, 8'h15, 8'h1A, 8'h12, 8'h5A, 8'h14, 8'h07,
                                 8'h7E, 8'h29, 8'h66, 8'h77, 8'h5B, 8'h11, 8'h4A};

  initial begin
    for (int i = 0; i < 256; i++) loc_of[i] = -1;
    for (int i = 0; i < 56; i++) if (layout[i] != 8'h00) loc_of[layout[i]] = i;
    model_reset();
    rst_n = 1'b0;
    bus.ps2_key_i = '0; bus.rd_i = 1'b0; bus.row_sel_i = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset col_o", bus.col_o, 8'h00);
    check("reset key_reset_o", {7'd0, bus.key_reset_o}, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    idle();

    // Press A, read row 3, release, read again
    press(8'h1C, 0);
    read_row(3'd3);  check("A pressed row3", bus.col_o, 8'h01);
    release_key(8'h1C, 0);
    read_row(3'd3);  check("A released row3", bus.col_o, 8'h00);

    // Short Q tap between scans is latched until read once
    press(8'h15, 0);
    release_key(8'h15, 0);
    read_row(3'd2);  check("Q latched row2", bus.col_o, 8'h01);
    read_row(3'd2);  check("Q cleared row2", bus.col_o, 8'h00);

    // Unread Z release is forced off by the timeout
    press(8'h1A, 0);
    release_key(8'h1A, 0);
    repeat (REL + 10) idle();
    read_row(3'd4);  check("Z timed out row4", bus.col_o, 8'h00);

    // Modifier row, extended right Ctrl, row 7
    press(8'h12, 0);
    press(8'h5A, 0);
    read_row(3'd0);  check("LSHIFT+RETURN row0", bus.col_o, 8'h84);
    release_key(8'h12, 0);
    release_key(8'h5A, 0);
    press(8'h14, 1);
    read_row(3'd0);  check("RCtrl row0", bus.col_o, 8'h01);
    read_row(3'd7);  check("row7", bus.col_o, 8'h00);
    release_key(8'h14, 1);
    press(8'h12, 1);
    read_row(3'd0);  check("E0-12 ignored row0", bus.col_o, 8'h00);
    release_key(8'h12, 1);

    // F12 and Scroll Lock drive RESET without touching the matrix
    press(8'h07, 0);
    check("F12 key_reset_o", {7'd0, bus.key_reset_o}, 8'h01);
    for (int r = 0; r < 7; r++) begin
      read_row(3'(r)); check("F12 rows clear", bus.col_o, 8'h00);
    end
    release_key(8'h07, 0);
    check("F12 release", {7'd0, bus.key_reset_o}, 8'h00);
    press(8'h7E, 0);
    check("ScrLk key_reset_o", {7'd0, bus.key_reset_o}, 8'h01);
    release_key(8'h7E, 0);

    // Reset mid-stream with a toggle edge arriving during reset
    press(8'h1C, 0);
    read_row(3'd3);  check("A before reset", bus.col_o, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset col_o", bus.col_o, 8'h00);
    bus.ps2_key_i = {~bus.ps2_key_i[10], 1'b1, 1'b0, 8'h07};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle();
    check("no spurious key_reset", {7'd0, bus.key_reset_o}, 8'h00);
    for (int r = 0; r < 7; r++) begin
      read_row(3'(r)); check("post-reset rows", bus.col_o, 8'h00);
    end

    // Random events and reads against the model
    for (int i = 0; i < 3000; i++) begin
      bit ev, pr, ext, rd;
      logic [7:0] code;
      logic [2:0] row;
      ev   = ($urandom_range(0, 3) == 0);
      pr   = $urandom_range(0, 1) == 1;
      ext  = ($urandom_range(0, 5) == 0);
      code = rnd_codes[$urandom_range(0, 13)];
      rd   = ($urandom_range(0, 5) == 0);
      row  = 3'($urandom_range(0, 7));
      step(ev, pr, ext, code, rd, row);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
